hough_vote_scheduler: RTL and testbench

Sequencing controller for the Hough circle accumulator BRAM (450×290 cells, 4-bit counts, separate write port A and read port B). It clears the accumulator at frame start and serialises candidate-centre votes into read-modify-write increments. At frame end it scans the whole array and reports the best centre as `idealX`/`idealY`. It sits between the edge/vote generator and the dual-port accumulator BRAM.

---
 rtl/hough_pkg.sv | 25 ++
 rtl/hough_peak_tracker.sv | 56 +++++
 rtl/hough_vote_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_hough_vote_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared sizes, FSM state type and the cell address helper for the Hough vote scheduler.
package hough_pkg;

    localparam int unsigned ACC_W  = 450;
    localparam int unsigned ACC_H  = 290;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StVote,
        StScan,
        StDone
    } state_e;

    // Full-width linear cell address; callers truncate to their BRAM address width.
    function automatic logic [31:0] cell_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                              input int unsigned acc_w);
        return 32'(y) * acc_w + 32'(x);
    endfunction

endpackage

// File: rtl/hough_peak_tracker.sv
// Running maximum of tagged accumulator samples; a tie keeps the earlier (lower address) cell.
module hough_peak_tracker
    import hough_pkg::*;
#(
    parameter int unsigned CntW = CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            valid_i,
    input  logic [CntW-1:0] sample_i,
    input  logic [X_W-1:0]  tag_x_i,
    input  logic [Y_W-1:0]  tag_y_i,
    output logic [CntW-1:0] best_o,
    output logic [X_W-1:0]  best_x_o,
    output logic [Y_W-1:0]  best_y_o
);

    logic [CntW-1:0] best_d, best_q;
    logic [X_W-1:0]  x_d, x_q;
    logic [Y_W-1:0]  y_d, y_q;

    // Clear to count 0 at (0,0); otherwise take a strictly greater sample.
    always_comb begin
        best_d = best_q;
        x_d    = x_q;
        y_d    = y_q;
        if (clear_i) begin
            best_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else if (valid_i && (sample_i > best_q)) begin
            best_d = sample_i;
            x_d    = tag_x_i;
            y_d    = tag_y_i;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            best_q <= best_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign best_o   = best_q;
    assign best_x_o = x_q;
    assign best_y_o = y_q;

endmodule

// File: rtl/hough_vote_scheduler.sv
// Clears the Hough accumulator BRAM, serialises votes as read-modify-write increments and
// scans the array at frame end to report the best circle centre.
module hough_vote_scheduler
    import hough_pkg::*;
#(
    parameter int unsigned AccW  = ACC_W,
    parameter int unsigned AccH  = ACC_H,
    parameter int unsigned AddrW = ADDR_W,
    parameter int unsigned CntW  = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             vote_valid,
    output logic             vote_ready,
    input  logic [X_W-1:0]   vote_x,
    input  logic [Y_W-1:0]   vote_y,
    output logic [AddrW-1:0] wr_addr,
    output logic [CntW-1:0]  wr_data,
    output logic             wr_en,
    output logic [AddrW-1:0] rd_addr,
    input  logic [CntW-1:0]  rd_data,
    output logic [X_W-1:0]   idealX,
    output logic [Y_W-1:0]   idealY,
    output logic [CntW-1:0]  best_count,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(AccW * AccH - 1);
    localparam logic [X_W-1:0]   LastX    = X_W'(AccW - 1);
    localparam logic [Y_W-1:0]   LastY    = Y_W'(AccH - 1);
    localparam logic [CntW-1:0]  CntMax   = '1;

    state_e           state_d, state_q;
    logic [AddrW-1:0] wr_addr_d, wr_addr_q, rd_addr_d, rd_addr_q, rmw_addr_d, rmw_addr_q;
    logic [CntW-1:0]  wr_data_d, wr_data_q, best_d, best_q;
    logic             wr_en_d, wr_en_q, ready_d, ready_q, end_pend_d, end_pend_q;
    logic [1:0]       stage_d, stage_q;  // 0: free, 1: read issued, 2: read data due
    logic [X_W-1:0]   scan_x_d, scan_x_q, tag_x_d, tag_x_q, ideal_x_d, ideal_x_q;
    logic [Y_W-1:0]   scan_y_d, scan_y_q, tag_y_d, tag_y_q, ideal_y_d, ideal_y_q;
    logic             issue_d, issue_q, tag_valid_d, tag_valid_q, tag_last_d, tag_last_q;
    logic             fin_d, fin_q, rv_d, rv_q;

    logic [AddrW-1:0] vote_addr;
    logic             vote_in_range, scan_last;
    logic [CntW-1:0]  trk_best;
    logic [X_W-1:0]   trk_x;
    logic [Y_W-1:0]   trk_y;

    assign vote_addr     = AddrW'(cell_addr(vote_x, vote_y, AccW));
    assign vote_in_range = (32'(vote_x) < AccW) && (32'(vote_y) < AccH);
    assign scan_last     = (scan_x_q == LastX) && (scan_y_q == LastY);

    // Scan tags trail the read address by two cycles to line up with returning data.
    hough_peak_tracker #(
        .CntW(CntW)
    ) u_peak (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (state_q != StScan),
        .valid_i (tag_valid_q),
        .sample_i(rd_data),
        .tag_x_i (tag_x_q),
        .tag_y_i (tag_y_q),
        .best_o  (trk_best),
        .best_x_o(trk_x),
        .best_y_o(trk_y)
    );

    // Next-state and registered-output logic; frame_start overrides every state.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rmw_addr_d  = rmw_addr_q;
        ready_d     = ready_q;
        end_pend_d  = end_pend_q;
        stage_d     = stage_q;
        scan_x_d    = scan_x_q;
        scan_y_d    = scan_y_q;
        issue_d     = issue_q;
        tag_x_d     = tag_x_q;
        tag_y_d     = tag_y_q;
        tag_valid_d = 1'b0;
        tag_last_d  = 1'b0;
        fin_d       = 1'b0;
        ideal_x_d   = ideal_x_q;
        ideal_y_d   = ideal_y_q;
        best_d      = best_q;
        rv_d        = rv_q;
        if (frame_start) begin
            state_d    = StClear;
            wr_addr_d  = '0;
            wr_data_d  = '0;
            wr_en_d    = 1'b1;
            ready_d    = 1'b0;
            end_pend_d = 1'b0;
            stage_d    = 2'd0;
            issue_d    = 1'b0;
            rv_d       = 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    if (wr_addr_q == LastAddr) begin
                        state_d = StVote;
                        ready_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + AddrW'(1);
                        wr_en_d   = 1'b1;
                    end
                end
                StVote: begin
                    if (frame_end) begin
                        end_pend_d = 1'b1;
                        ready_d    = 1'b0;
                    end
                    case (stage_q)
                        2'd0: begin
                            if (vote_valid && ready_q) begin
                                // Out-of-range votes are consumed without touching the BRAM.
                                if (vote_in_range) begin
                                    rd_addr_d  = vote_addr;
                                    rmw_addr_d = vote_addr;
                                    stage_d    = 2'd1;
                                    ready_d    = 1'b0;
                                end
                            end else if (end_pend_q) begin
                                state_d    = StScan;
                                end_pend_d = 1'b0;
                                rd_addr_d  = '0;
                                scan_x_d   = '0;
                                scan_y_d   = '0;
                                issue_d    = 1'b1;
                            end
                        end
                        2'd1: stage_d = 2'd2;
                        2'd2: begin
                            wr_addr_d = rmw_addr_q;
                            wr_data_d = (rd_data == CntMax) ? CntMax : rd_data + CntW'(1);
                            wr_en_d   = 1'b1;
                            stage_d   = 2'd0;
                            ready_d   = !(end_pend_q || frame_end);
                        end
                        default: stage_d = 2'd0;
                    endcase
                end
                StScan: begin
                    tag_x_d     = scan_x_q;
                    tag_y_d     = scan_y_q;
                    tag_valid_d = issue_q;
                    tag_last_d  = scan_last;
                    fin_d       = tag_valid_q && tag_last_q;
                    if (issue_q) begin
                        if (scan_last) begin
                            issue_d = 1'b0;
                        end else begin
                            rd_addr_d = rd_addr_q + AddrW'(1);
                            if (scan_x_q == LastX) begin
                                scan_x_d = '0;
                                scan_y_d = scan_y_q + Y_W'(1);
                            end else begin
                                scan_x_d = scan_x_q + X_W'(1);
                            end
                        end
                    end
                    if (fin_q) begin
                        state_d   = StDone;
                        ideal_x_d = trk_x;
                        ideal_y_d = trk_y;
                        best_d    = trk_best;
                        rv_d      = 1'b1;
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rmw_addr_q  <= '0;
            ready_q     <= 1'b0;
            end_pend_q  <= 1'b0;
            stage_q     <= 2'd0;
            scan_x_q    <= '0;
            scan_y_q    <= '0;
            issue_q     <= 1'b0;
            tag_x_q     <= '0;
            tag_y_q     <= '0;
            tag_valid_q <= 1'b0;
            tag_last_q  <= 1'b0;
            fin_q       <= 1'b0;
            ideal_x_q   <= '0;
            ideal_y_q   <= '0;
            best_q      <= '0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_addr_q   <= rd_addr_d;
            rmw_addr_q  <= rmw_addr_d;
            ready_q     <= ready_d;
            end_pend_q  <= end_pend_d;
            stage_q     <= stage_d;
            scan_x_q    <= scan_x_d;
            scan_y_q    <= scan_y_d;
            issue_q     <= issue_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
            fin_q       <= fin_d;
            ideal_x_q   <= ideal_x_d;
            ideal_y_q   <= ideal_y_d;
            best_q      <= best_d;
            rv_q        <= rv_d;
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_en        = wr_en_q;
    assign rd_addr      = rd_addr_q;
    assign vote_ready   = ready_q;
    assign idealX       = ideal_x_q;
    assign idealY       = ideal_y_q;
    assign best_count   = best_q;
    assign result_valid = rv_q;
    assign busy         = (state_q == StClear) || (state_q == StScan) || (stage_q != 2'd0) ||
                          ((state_q == StVote) && wr_en_q);

endmodule

// File: tb/tb_hough_vote_scheduler.sv
// Scoreboard bench: stimulus pushes expected RMW writes and frame results computed from a plain
// accumulator array; monitors pop and compare when the DUT writes or raises result_valid.
module tb_hough_vote_scheduler;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int AW = 18;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, frame_start, frame_end, vote_valid;
    logic          vote_ready, wr_en, result_valid, busy;
    logic [9:0]    vote_x, idealX;
    logic [8:0]    vote_y, idealY;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [CW-1:0] wr_data, rd_data, best_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic clearing = 1'b0;

    logic [CW-1:0] mem [0:(1<<AW)-1];
    int            ref_acc [N];

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int x; int y; int cnt;} res_t;
    wr_t  exp_wr_q[$];
    res_t exp_res_q[$];
    int   acc_cyc[$];

    hough_vote_scheduler #(
        .AccW (W),
        .AccH (H),
        .AddrW(AW),
        .CntW (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .vote_valid  (vote_valid),
        .vote_ready  (vote_ready),
        .vote_x      (vote_x),
        .vote_y      (vote_y),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .idealX      (idealX),
        .idealY      (idealY),
        .best_count  (best_count),
        .result_valid(result_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dual-port BRAM with one-cycle registered read.
    initial begin
        rd_data = '0;
        forever begin
            @(posedge clk);
            if (wr_en) mem[wr_addr] <= wr_data;
            rd_data <= mem[rd_addr];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write monitor: every write outside a clear must be the next expected RMW write.
    initial forever begin
        @(negedge clk);
        if (wr_en && !clearing && !rst) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: addr %0d data %0d, none expected",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("rmw_wr_addr", int'(wr_addr), e.addr);
                check("rmw_wr_data", int'(wr_data), e.data);
            end
        end
    end

    // Result monitor: compare on each rising edge of result_valid.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !prev) begin
                if (exp_res_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: x %0d y %0d cnt %0d", idealX, idealY,
                             best_count);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    check("result_x", int'(idealX), r.x);
                    check("result_y", int'(idealY), r.y);
                    check("result_cnt", int'(best_count), r.cnt);
                end
            end
            prev = result_valid;
        end
    end

    initial forever begin
        @(negedge clk);
        if (vote_valid && vote_ready && !rst) acc_cyc.push_back(cyc);
    end

    task automatic do_clear();
        int k;
        bit ok;
        k  = 0;
        ok = 1'b1;
        clearing    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) ref_acc[i] = 0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(negedge clk);
            if (!wr_en) break;
            if (int'(wr_addr) != k || wr_data != '0 || vote_ready || result_valid) ok = 1'b0;
            k++;
        end
        check("clear_len", k, N);
        check("clear_seq_ok", int'(ok), 1);
        check("ready_after_clear", int'(vote_ready), 1);
        clearing = 1'b0;
    endtask

    task automatic send_vote(input int x, input int y);
        int a;
        bit inr;
        bit got;
        got = 1'b0;
        a   = 0;
        tick();
        vote_x     = 10'(x);
        vote_y     = 9'(y);
        vote_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vote_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("vote_accept_timeout", 0, 1);
            vote_valid = 1'b0;
            return;
        end
        tick();
        vote_valid = 1'b0;
        inr = (x < W) && (y < H);
        if (inr) begin
            wr_t e;
            a = y * W + x;
            ref_acc[a] = (ref_acc[a] == 15) ? 15 : ref_acc[a] + 1;
            e.addr = a;
            e.data = ref_acc[a];
            exp_wr_q.push_back(e);
        end
        @(negedge clk);
        if (inr) begin
            check("rd_addr_on_accept", int'(rd_addr), a);
            check("ready_low_in_rmw", int'(vote_ready), 0);
        end else begin
            check("ready_stays_high_oor", int'(vote_ready), 1);
        end
    endtask

    task automatic end_frame();
        res_t r;
        r.x   = 0;
        r.y   = 0;
        r.cnt = 0;
        for (int a = 0; a < N; a++) begin
            if (ref_acc[a] > r.cnt) begin
                r.cnt = ref_acc[a];
                r.x   = a % W;
                r.y   = a / W;
            end
        end
        exp_res_q.push_back(r);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_result();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3 * N + 50; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("result_timeout", 0, 1);
        repeat (3) @(negedge clk);
        if (got) check("result_holds", int'(result_valid), 1);
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        vote_valid  = 1'b0;
        vote_x      = '0;
        vote_y      = '0;
        repeat (3) tick();
        check("reset_ctrl", int'({vote_ready, wr_en, result_valid, busy}), 0);
        check("reset_result", int'({idealX, idealY, best_count}), 0);
        rst = 1'b0;
        tick();

        // Single vote.
        do_clear();
        send_vote(10, 5);
        end_frame();
        wait_result();

        // Saturation at 15.
        do_clear();
        for (int i = 0; i < 16; i++) send_vote(12, 6);
        end_frame();
        wait_result();

        // Tie: the lower address (7,3) must win over (5,5).
        do_clear();
        for (int i = 0; i < 3; i++) begin
            send_vote(5, 5);
            send_vote(7, 3);
        end
        end_frame();
        wait_result();

        // Out-of-range votes are dropped.
        do_clear();
        send_vote(W, 0);
        send_vote(0, H);
        end_frame();
        wait_result();

        // Back-to-back votes, frame_end lands during the last RMW.
        do_clear();
        acc_cyc.delete();
        send_vote(1, 0);
        send_vote(2, 0);
        send_vote(3, 0);
        send_vote(4, 1);
        end_frame();
        check("accept_count", acc_cyc.size(), 4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            check("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        @(negedge clk);
        check("ready_low_after_end", int'(vote_ready), 0);
        wait_result();

        // Randomised frame biased toward a small hot region to get repeats and ties.
        do_clear();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) send_vote($urandom_range(0, 3), $urandom_range(0, 2));
            else send_vote($urandom_range(0, W), $urandom_range(0, H));
        end
        end_frame();
        wait_result();

        // frame_start during SCAN restarts CLEAR and discards the pending result.
        do_clear();
        send_vote(3, 2);
        end_frame();
        exp_res_q.delete();
        repeat (20) @(negedge clk);
        check("busy_in_scan", int'(busy), 1);
        do_clear();
        check("rv_low_after_abort", int'(result_valid), 0);
        send_vote(5, 4);
        end_frame();
        wait_result();

        // Reset during CLEAR returns every output to 0.
        clearing    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        check("wr_en_mid_clear", int'(wr_en), 1);
        rst = 1'b1;
        #1;
        check("rst_ctrl", int'({vote_ready, wr_en, result_valid, busy}), 0);
        check("rst_addrs", int'(wr_addr | rd_addr), 0);
        check("rst_result", int'({idealX, idealY, best_count, wr_data}), 0);
        tick();
        rst      = 1'b0;
        clearing = 1'b0;
        repeat (3) tick();

        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("res_queue_drained", exp_res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
